// File: rtl/stream_cipher_pkg.sv
// Shared types and constants for the byte-oriented UART stream cipher.
// Holds the frame FSM states, mode encodings and an address-width helper.
package stream_cipher_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    GET_LEN,
    GET_DATA,
    GET_KLEN,
    GET_KEY,
    PROCESS,
    SEND_LEN,
    SEND_DATA,
    WAIT_TX
  } state_t;

  typedef enum logic [1:0] {
    MODE_XOR       = 2'b00,
    MODE_CHAIN_ENC = 2'b01,
    MODE_CHAIN_DEC = 2'b10,
    MODE_RSVD      = 2'b11
  } mode_t;

  // Memory address width; a single-entry memory still gets one address bit.
  function automatic int addrBits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/stream_cipher_datapath.sv
// Combinational cipher step: result = data ^ key ^ chain, where the chain
// byte is chosen by the frame's latched mode.
module cipher_datapath
  import stream_cipher_pkg::*;
(
  input  mode_t             mode,
  input  logic [BYTE_W-1:0] dataByte,
  input  logic [BYTE_W-1:0] keyByte,
  input  logic [BYTE_W-1:0] prevData,
  input  logic [BYTE_W-1:0] prevRes,
  output logic [BYTE_W-1:0] resByte
);

  logic [BYTE_W-1:0] chainByte;

  // prevData/prevRes already hold IV for the first byte of a frame.
  always_comb begin
    chainByte = '0;
    case (mode)
      MODE_CHAIN_ENC: chainByte = prevRes;
      MODE_CHAIN_DEC: chainByte = prevData;
      default:        chainByte = '0;
    endcase
  end

  assign resByte = dataByte ^ keyByte ^ chainByte;

endmodule

// File: rtl/stream_cipher.sv
// Frame-level stream cipher: parses LEN/data/KLEN/key from the UART receiver,
// encrypts the frame one byte per cycle and streams LEN plus results to the sender.
module stream_cipher
  import stream_cipher_pkg::*;
#(
  parameter int                MAX_DATA = 100,
  parameter int                MAX_KEY  = 4,
  parameter logic [BYTE_W-1:0] IV       = 8'h00
) (
  input  logic              Clk_100M,
  input  logic              Reset,
  input  logic [1:0]        Mode,
  input  logic [BYTE_W-1:0] Rx_Data,
  input  logic              Rx_Ready,
  output logic              Rx_Ack,
  output logic [BYTE_W-1:0] Tx_Data,
  output logic              Tx_Send,
  input  logic              Tx_Busy,
  input  logic [BYTE_W-1:0] View_Index,
  output logic [BYTE_W-1:0] View_Plain,
  output logic [BYTE_W-1:0] View_Cipher,
  output logic              Frame_Done,
  output logic              Err
);

  localparam int DAW = addrBits(MAX_DATA);
  localparam int KAW = addrBits(MAX_KEY);
  localparam logic [BYTE_W-1:0] MAX_DATA_B = BYTE_W'(MAX_DATA);
  localparam logic [BYTE_W-1:0] MAX_KEY_B  = BYTE_W'(MAX_KEY);

  logic [BYTE_W-1:0] dataMem [2**DAW];
  logic [BYTE_W-1:0] keyMem  [2**KAW];
  logic [BYTE_W-1:0] resMem  [2**DAW];

  state_t            state;
  mode_t             frameMode;
  logic [BYTE_W-1:0] frameLen, keyLen, byteIdx, keyIdx;
  logic [BYTE_W-1:0] prevData, prevRes, txData;
  logic              rxAck, txSend, frameDone, errFlag, busySeen;

  logic              inGet, rxAccept, dataWe, keyWe, resWe;
  logic [BYTE_W-1:0] curData, curKey, resByte, sendByte;

  assign inGet    = (state == GET_LEN) || (state == GET_DATA) ||
                    (state == GET_KLEN) || (state == GET_KEY);
  assign rxAccept = inGet && Rx_Ready && !rxAck;
  assign dataWe   = !Reset && rxAccept && (state == GET_DATA);
  assign keyWe    = !Reset && rxAccept && (state == GET_KEY);
  assign resWe    = !Reset && (state == PROCESS);

  assign curData  = dataMem[byteIdx[DAW-1:0]];
  assign curKey   = keyMem[keyIdx[KAW-1:0]];
  assign sendByte = resMem[byteIdx[DAW-1:0]];

  cipher_datapath uDatapath (
    .mode     (frameMode),
    .dataByte (curData),
    .keyByte  (curKey),
    .prevData (prevData),
    .prevRes  (prevRes),
    .resByte  (resByte)
  );

  // Single-write-port memories, never reset so results survive for viewing.
  always_ff @(posedge Clk_100M) begin
    if (dataWe) dataMem[byteIdx[DAW-1:0]] <= Rx_Data;
  end

  always_ff @(posedge Clk_100M) begin
    if (keyWe) keyMem[keyIdx[KAW-1:0]] <= Rx_Data;
  end

  always_ff @(posedge Clk_100M) begin
    if (resWe) resMem[byteIdx[DAW-1:0]] <= resByte;
  end

  always_ff @(posedge Clk_100M) begin
    if (Reset) begin
      state     <= GET_LEN;
      frameMode <= MODE_XOR;
      frameLen  <= '0;
      keyLen    <= '0;
      byteIdx   <= '0;
      keyIdx    <= '0;
      prevData  <= '0;
      prevRes   <= '0;
      txData    <= '0;
      rxAck     <= 1'b0;
      txSend    <= 1'b0;
      frameDone <= 1'b0;
      errFlag   <= 1'b0;
      busySeen  <= 1'b0;
    end else begin
      txSend    <= 1'b0;
      frameDone <= 1'b0;

      if (rxAccept)       rxAck <= 1'b1;
      else if (!Rx_Ready) rxAck <= 1'b0;

      case (state)
        GET_LEN: if (rxAccept) begin
          if (Rx_Data == '0 || Rx_Data > MAX_DATA_B) begin
            errFlag <= 1'b1;
          end else begin
            errFlag   <= 1'b0;
            frameLen  <= Rx_Data;
            frameMode <= mode_t'(Mode);
            byteIdx   <= '0;
            state     <= GET_DATA;
          end
        end
        GET_DATA: if (rxAccept) begin
          if (byteIdx == frameLen - 8'd1) begin
            byteIdx <= '0;
            state   <= GET_KLEN;
          end else begin
            byteIdx <= byteIdx + 8'd1;
          end
        end
        GET_KLEN: if (rxAccept) begin
          if (Rx_Data == '0 || Rx_Data > MAX_KEY_B) begin
            errFlag <= 1'b1;
            state   <= GET_LEN;
          end else begin
            keyLen <= Rx_Data;
            keyIdx <= '0;
            state  <= GET_KEY;
          end
        end
        GET_KEY: if (rxAccept) begin
          if (keyIdx == keyLen - 8'd1) begin
            keyIdx   <= '0;
            byteIdx  <= '0;
            prevData <= IV;
            prevRes  <= IV;
            state    <= PROCESS;
          end else begin
            keyIdx <= keyIdx + 8'd1;
          end
        end
        PROCESS: begin
          prevData <= curData;
          prevRes  <= resByte;
          keyIdx   <= (keyIdx == keyLen - 8'd1) ? '0 : keyIdx + 8'd1;
          if (byteIdx == frameLen - 8'd1) begin
            byteIdx <= '0;
            state   <= SEND_LEN;
          end else begin
            byteIdx <= byteIdx + 8'd1;
          end
        end
        SEND_LEN: if (!Tx_Busy) begin
          txData   <= frameLen;
          txSend   <= 1'b1;
          busySeen <= 1'b0;
          state    <= WAIT_TX;
        end
        SEND_DATA: if (!Tx_Busy) begin
          txData   <= sendByte;
          txSend   <= 1'b1;
          byteIdx  <= byteIdx + 8'd1;
          busySeen <= 1'b0;
          state    <= WAIT_TX;
        end
        // byteIdx counts result bytes already handed over; equal to LEN means done.
        WAIT_TX: begin
          if (Tx_Busy) begin
            busySeen <= 1'b1;
          end else if (busySeen) begin
            if (byteIdx == frameLen) begin
              frameDone <= 1'b1;
              state     <= GET_LEN;
            end else begin
              state <= SEND_DATA;
            end
          end
        end
        default: state <= GET_LEN;
      endcase
    end
  end

  assign Rx_Ack      = rxAck;
  assign Tx_Data     = txData;
  assign Tx_Send     = txSend;
  assign Frame_Done  = frameDone;
  assign Err         = errFlag;
  assign View_Plain  = (View_Index < frameLen) ? dataMem[View_Index[DAW-1:0]] : '0;
  assign View_Cipher = (View_Index < frameLen) ? resMem[View_Index[DAW-1:0]] : '0;

endmodule

// File: tb/tb_stream_cipher.sv
// Directed bench for stream_cipher: drives UART-style frames, models a busy
// sender, and checks transmitted bytes, flags and viewer outputs.
module tb_stream_cipher;

  logic       Clk_100M, Reset, Rx_Ready, Rx_Ack, Tx_Send, Tx_Busy, Frame_Done, Err;
  logic [1:0] Mode;
  logic [7:0] Rx_Data, Tx_Data, View_Index, View_Plain, View_Cipher;

  int compared = 0;
  int mismatched = 0;

  logic [7:0] txLog [256];
  int txCount = 0;
  int frameDoneCnt = 0;
  int sendWhileBusy = 0;
  int busyRemain = 0;
  int busyLen = 2;

  logic [7:0] dBuf [8];
  logic [7:0] kBuf [8];
  logic [7:0] eBuf [8];

  stream_cipher #(.MAX_DATA(100), .MAX_KEY(4), .IV(8'h00)) dut (
    .Clk_100M    (Clk_100M),
    .Reset       (Reset),
    .Mode        (Mode),
    .Rx_Data     (Rx_Data),
    .Rx_Ready    (Rx_Ready),
    .Rx_Ack      (Rx_Ack),
    .Tx_Data     (Tx_Data),
    .Tx_Send     (Tx_Send),
    .Tx_Busy     (Tx_Busy),
    .View_Index  (View_Index),
    .View_Plain  (View_Plain),
    .View_Cipher (View_Cipher),
    .Frame_Done  (Frame_Done),
    .Err         (Err)
  );

  initial Clk_100M = 1'b0;
  always #5 Clk_100M = ~Clk_100M;

  initial Tx_Busy = 1'b0;

  // UART sender model: captures each strobe, then stays busy for busyLen cycles.
  always @(negedge Clk_100M) begin
    if (Tx_Send) begin
      if (Tx_Busy) sendWhileBusy++;
      if (txCount < 256) txLog[txCount] = Tx_Data;
      txCount++;
      busyRemain = busyLen;
      Tx_Busy = (busyLen > 0);
    end else if (busyRemain > 0) begin
      busyRemain--;
      if (busyRemain == 0) Tx_Busy = 1'b0;
    end
    if (Frame_Done) frameDoneCnt++;
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic rxByte(input logic [7:0] b);
    int t;
    Rx_Data = b;
    Rx_Ready = 1'b1;
    t = 0;
    while (!Rx_Ack && t < 200) begin @(negedge Clk_100M); t++; end
    check("rx_ack_rise", (t < 200), 1);
    Rx_Ready = 1'b0;
    t = 0;
    while (Rx_Ack && t < 200) begin @(negedge Clk_100M); t++; end
    check("rx_ack_fall", (t < 200), 1);
  endtask

  task automatic doFrame(input string tag, input logic [1:0] m, input logic [1:0] mAfter,
                         input int len, input int klen);
    int startTx, startFd, t;
    startTx = txCount;
    startFd = frameDoneCnt;
    Mode = m;
    rxByte(8'(len));
    Mode = mAfter;
    for (int i = 0; i < len; i++) rxByte(dBuf[i]);
    rxByte(8'(klen));
    for (int i = 0; i < klen; i++) rxByte(kBuf[i]);
    t = 0;
    while (frameDoneCnt == startFd && t < 20000) begin @(negedge Clk_100M); t++; end
    check({tag, "_done_timeout"}, (t < 20000), 1);
    repeat (5) @(negedge Clk_100M);
    check({tag, "_frame_done_cnt"}, frameDoneCnt - startFd, 1);
    check({tag, "_tx_count"}, txCount - startTx, len + 1);
    check({tag, "_tx_len"}, txLog[startTx], len);
    for (int i = 0; i < len; i++) begin
      check($sformatf("%s_tx_res%0d", tag, i), txLog[startTx + 1 + i], eBuf[i]);
      $display("%s: byte %0d tx=%02h exp=%02h", tag, i, txLog[startTx + 1 + i], eBuf[i]);
    end
  endtask

  initial begin
    int startTx, t;
    Reset = 1'b1; Mode = 2'b00; Rx_Data = 8'h00; Rx_Ready = 1'b0; View_Index = 8'h00;
    repeat (3) @(negedge Clk_100M);
    check("rst_rx_ack", Rx_Ack, 0);
    check("rst_tx_send", Tx_Send, 0);
    check("rst_tx_data", Tx_Data, 0);
    check("rst_frame_done", Frame_Done, 0);
    check("rst_err", Err, 0);
    check("rst_view_plain", View_Plain, 0);
    check("rst_view_cipher", View_Cipher, 0);
    Reset = 1'b0;
    @(negedge Clk_100M);

    // Plain XOR with key wrap; Mode flipped after LEN must not matter.
    dBuf = '{8'h41, 8'h42, 8'h43, 0, 0, 0, 0, 0};
    kBuf = '{8'h0F, 8'hF0, 0, 0, 0, 0, 0, 0};
    eBuf = '{8'h4E, 8'hB2, 8'h4C, 0, 0, 0, 0, 0};
    doFrame("xor", 2'b00, 2'b01, 3, 2);
    View_Index = 8'd0; #1;
    check("view_plain0", View_Plain, 8'h41);
    check("view_cipher0", View_Cipher, 8'h4E);
    View_Index = 8'd2; #1;
    check("view_plain2", View_Plain, 8'h43);
    check("view_cipher2", View_Cipher, 8'h4C);
    View_Index = 8'd3; #1;
    check("view_plain_oob", View_Plain, 8'h00);
    check("view_cipher_oob", View_Cipher, 8'h00);
    @(negedge Clk_100M);

    dBuf = '{8'h10, 8'h20, 0, 0, 0, 0, 0, 0};
    kBuf = '{8'h01, 0, 0, 0, 0, 0, 0, 0};
    eBuf = '{8'h11, 8'h30, 0, 0, 0, 0, 0, 0};
    doFrame("chain_enc", 2'b01, 2'b01, 2, 1);

    dBuf = '{8'h11, 8'h30, 0, 0, 0, 0, 0, 0};
    eBuf = '{8'h10, 8'h20, 0, 0, 0, 0, 0, 0};
    doFrame("chain_dec", 2'b10, 2'b00, 2, 1);

    dBuf = '{8'hAA, 0, 0, 0, 0, 0, 0, 0};
    kBuf = '{8'h55, 0, 0, 0, 0, 0, 0, 0};
    eBuf = '{8'hFF, 0, 0, 0, 0, 0, 0, 0};
    doFrame("mode11", 2'b11, 2'b11, 1, 1);

    // LEN and KLEN format errors.
    Mode = 2'b00;
    startTx = txCount;
    rxByte(8'h00);
    check("err_len0", Err, 1);
    rxByte(8'hC8);
    check("err_len200", Err, 1);
    rxByte(8'h01);
    check("err_clear_len1", Err, 0);
    rxByte(8'h5A);
    rxByte(8'h05);
    check("err_klen5", Err, 1);
    repeat (20) @(negedge Clk_100M);
    check("err_no_tx", txCount - startTx, 0);
    dBuf = '{8'h00, 0, 0, 0, 0, 0, 0, 0};
    kBuf = '{8'hFF, 0, 0, 0, 0, 0, 0, 0};
    eBuf = '{8'hFF, 0, 0, 0, 0, 0, 0, 0};
    doFrame("after_err", 2'b00, 2'b00, 1, 1);
    check("err_after_good", Err, 0);

    // Long sender busy time.
    busyLen = 50;
    dBuf = '{8'h01, 8'h02, 0, 0, 0, 0, 0, 0};
    kBuf = '{8'h03, 0, 0, 0, 0, 0, 0, 0};
    eBuf = '{8'h02, 8'h01, 0, 0, 0, 0, 0, 0};
    doFrame("busy50", 2'b00, 2'b00, 2, 1);
    check("no_send_while_busy", sendWhileBusy, 0);

    // Reset during SEND_DATA after LEN plus two result bytes.
    busyLen = 5;
    startTx = txCount;
    Mode = 2'b00;
    rxByte(8'd4);
    rxByte(8'h01); rxByte(8'h02); rxByte(8'h03); rxByte(8'h04);
    rxByte(8'd1);
    rxByte(8'h10);
    t = 0;
    while (txCount - startTx < 3 && t < 2000) begin @(negedge Clk_100M); t++; end
    check("rst_mid_wait", (t < 2000), 1);
    check("rst_mid_byte2", txLog[startTx + 2], 8'h12);
    Reset = 1'b1;
    @(negedge Clk_100M);
    Reset = 1'b0;
    repeat (100) @(negedge Clk_100M);
    check("rst_mid_no_more_tx", txCount - startTx, 3);
    View_Index = 8'd0; #1;
    check("rst_mid_view_plain", View_Plain, 0);
    check("rst_mid_view_cipher", View_Cipher, 0);
    check("rst_mid_tx_data", Tx_Data, 0);
    @(negedge Clk_100M);
    busyLen = 2;
    dBuf = '{8'h5A, 8'hA5, 0, 0, 0, 0, 0, 0};
    kBuf = '{8'hFF, 0, 0, 0, 0, 0, 0, 0};
    eBuf = '{8'hA5, 8'h5A, 0, 0, 0, 0, 0, 0};
    doFrame("post_rst", 2'b00, 2'b00, 2, 1);
    check("final_no_send_while_busy", sendWhileBusy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
